// File: rtl/arb_pkg.sv
// Shared types for the memory port arbiter: FSM state, owner and latched command.
package arb_pkg;

    localparam int unsigned ARB_AW_MAX = 64;
    localparam int unsigned ARB_CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    // addr is sized for the widest supported AW; only the low AW bits are meaningful
    typedef struct packed {
        logic                  we;
        logic [3:0]            be;
        logic [ARB_AW_MAX-1:0] addr;
        logic [31:0]           wdata;
        arb_owner_e            owner;
    } arb_cmd_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner selection between fetch and load/store requesters.
// ARB_ROUND_ROBIN_EN selects alternating grants; otherwise load/store has fixed priority.
module mem_arb_sel
    import arb_pkg::*;
(
    input  logic       if_req_i,
    input  logic       ls_req_i,
    input  arb_owner_e last_owner_i,
    output arb_owner_e owner_o,
    output logic       valid_o
);

    assign valid_o = if_req_i | ls_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        owner_o = OWN_IF;
        if (if_req_i && ls_req_i) begin
            owner_o = (last_owner_i == OWN_LS) ? OWN_IF : OWN_LS;
        end else if (ls_req_i) begin
            owner_o = OWN_LS;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = last_owner_i;

    always_comb begin
        owner_o = ls_req_i ? OWN_LS : OWN_IF;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single fixed-latency memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is ls-over-if priority.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned AW      = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [31:0]   if_rdata_o,

    input  logic          ls_req_i,
    input  logic          ls_we_i,
    input  logic [3:0]    ls_be_i,
    input  logic [AW-1:0] ls_addr_i,
    input  logic [31:0]   ls_wdata_i,
    output logic          ls_gnt_o,
    output logic          ls_rvalid_o,
    output logic [31:0]   ls_rdata_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,

    output logic          busy_o
);

    localparam logic [ARB_CNT_W-1:0] LAT_M1 = ARB_CNT_W'(MEM_LAT - 1);

    if (MEM_LAT == 0 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end
    if (AW == 0 || AW > ARB_AW_MAX) begin : g_bad_aw
        $error("mem_port_arbiter: AW out of supported range");
    end

    arb_state_e           r_state;
    logic [ARB_CNT_W-1:0] r_cnt;
    arb_cmd_t             r_cmd;

    arb_owner_e w_last_owner;
    arb_owner_e w_sel_owner;
    logic       w_sel_valid;
    logic       w_gnt;
    logic       w_busy;
    logic       w_done;
    arb_cmd_t   w_next_cmd;
    logic       w_unused_addr;

    mem_arb_sel u_sel (
        .if_req_i     (if_req_i),
        .ls_req_i     (ls_req_i),
        .last_owner_i (w_last_owner),
        .owner_o      (w_sel_owner),
        .valid_o      (w_sel_valid)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_e r_last_owner;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_owner <= OWN_IF;
        end else if (w_gnt) begin
            r_last_owner <= w_sel_owner;
        end
    end

    assign w_last_owner = r_last_owner;
`else
    assign w_last_owner = OWN_IF;
`endif

    // Grant is combinational but suppressed while reset is asserted so all outputs read 0.
    assign w_gnt  = rst_ni & (r_state == IDLE) & w_sel_valid;
    assign w_busy = (r_state == BUSY);
    assign w_done = w_busy & (r_cnt == '0);

    always_comb begin
        w_next_cmd = '0;
        if (w_sel_owner == OWN_LS) begin
            w_next_cmd.we            = ls_we_i;
            w_next_cmd.be            = ls_be_i;
            w_next_cmd.addr[AW-1:0]  = ls_addr_i;
            w_next_cmd.wdata         = ls_wdata_i;
            w_next_cmd.owner         = OWN_LS;
        end else begin
            w_next_cmd.be            = 4'hF;
            w_next_cmd.addr[AW-1:0]  = if_addr_i;
            w_next_cmd.owner         = OWN_IF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cmd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_cmd   <= w_next_cmd;
                        r_cnt   <= LAT_M1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_gnt_o = w_gnt & (w_sel_owner == OWN_IF);
    assign ls_gnt_o = w_gnt & (w_sel_owner == OWN_LS);
    assign busy_o   = w_busy;

    assign mem_req_o   = w_busy;
    assign mem_we_o    = w_busy & r_cmd.we;
    assign mem_be_o    = w_busy ? r_cmd.be : 4'h0;
    assign mem_addr_o  = w_busy ? r_cmd.addr[AW-1:0] : '0;
    assign mem_wdata_o = w_busy ? r_cmd.wdata : 32'h0;

    assign if_rvalid_o = w_done & (r_cmd.owner == OWN_IF);
    assign ls_rvalid_o = w_done & (r_cmd.owner == OWN_LS);

    // Write completions return zero data.
    assign if_rdata_o = if_rvalid_o ? mem_rdata_i : 32'h0;
    assign ls_rdata_o = (ls_rvalid_o && !r_cmd.we) ? mem_rdata_i : 32'h0;

    assign w_unused_addr = ^r_cmd.addr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; honours ARB_ROUND_ROBIN_EN for the contention test.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // MEM_LAT=2 instance
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_req, mem_we, busy;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // MEM_LAT=1 instance, fetch port only
    logic        u1_if_req, u1_if_gnt, u1_if_rvalid;
    logic [31:0] u1_if_addr, u1_if_rdata;
    logic        u1_ls_req, u1_ls_we, u1_ls_gnt, u1_ls_rvalid;
    logic [3:0]  u1_ls_be;
    logic [31:0] u1_ls_addr, u1_ls_wdata, u1_ls_rdata;
    logic        u1_mem_req, u1_mem_we, u1_busy;
    logic [3:0]  u1_mem_be;
    logic [31:0] u1_mem_addr, u1_mem_wdata, u1_mem_rdata;

    mem_port_arbiter #(.MEM_LAT(2), .AW(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    mem_port_arbiter #(.MEM_LAT(1), .AW(32)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(u1_if_req), .if_addr_i(u1_if_addr), .if_gnt_o(u1_if_gnt),
        .if_rvalid_o(u1_if_rvalid), .if_rdata_o(u1_if_rdata),
        .ls_req_i(u1_ls_req), .ls_we_i(u1_ls_we), .ls_be_i(u1_ls_be), .ls_addr_i(u1_ls_addr),
        .ls_wdata_i(u1_ls_wdata), .ls_gnt_o(u1_ls_gnt), .ls_rvalid_o(u1_ls_rvalid),
        .ls_rdata_o(u1_ls_rdata),
        .mem_req_o(u1_mem_req), .mem_we_o(u1_mem_we), .mem_be_o(u1_mem_be),
        .mem_addr_o(u1_mem_addr), .mem_wdata_o(u1_mem_wdata), .mem_rdata_i(u1_mem_rdata),
        .busy_o(u1_busy)
    );

    typedef struct {
        bit          ls;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: every rvalid pops the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!if_rvalid) chk("if_rdata_idle", 64'(if_rdata), 64'd0);
            if (!ls_rvalid) chk("ls_rdata_idle", 64'(ls_rdata), 64'd0);
            if (if_rvalid || ls_rvalid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rvalid_unexpected: actual if=%0b ls=%0b required none (cycle %0d)",
                             if_rvalid, ls_rvalid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_owner", 64'({if_rvalid, ls_rvalid}), e.ls ? 64'd1 : 64'd2);
                    chk("rvalid_data", 64'(e.ls ? ls_rdata : if_rdata), 64'(e.rdata));
                    chk("rvalid_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_gnt(input bit own_ls, output int gc, output bit ok);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (own_ls ? ls_gnt : if_gnt) begin
                gc = cyc;
                ok = 1'b1;
                return;
            end
        end
        gc = -1;
        ok = 1'b0;
        checks++;
        failures++;
        $display("FAIL gnt_timeout: actual=no grant required=grant (owner ls=%0b)", own_ls);
    endtask

    // Entered and left at posedge+1; checks the held memory command on both BUSY cycles.
    task automatic do_txn(input bit own_ls, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, output int wait_cyc);
        int rc, gc;
        bit ok;
        rc = cyc;
        if (own_ls) begin
            ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        wait_gnt(own_ls, gc, ok);
        wait_cyc = ok ? gc - rc : -1;
        if (ok) begin
            chk("other_gnt_low", 64'(own_ls ? if_gnt : ls_gnt), 64'd0);
            sb.push_back('{ls: own_ls, rdata: exp_rdata, due: gc + 2});
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        ls_req = 1'b0;
        if (!ok) return;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("busy_mem_req", 64'(mem_req), 64'd1);
            chk("busy_flag", 64'(busy), 64'd1);
            chk("busy_mem_we", 64'(mem_we), own_ls ? 64'(we) : 64'd0);
            chk("busy_mem_be", 64'(mem_be), own_ls ? 64'(be) : 64'hF);
            chk("busy_mem_addr", 64'(mem_addr), 64'(addr));
            chk("busy_mem_wdata", 64'(mem_wdata), own_ls ? 64'(wdata) : 64'd0);
            chk("busy_no_gnt", 64'(if_gnt | ls_gnt), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int  w, gc, gc2, k;
        bit  ok, ok2, exp_ls;

        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
        mem_rdata = 0;
        u1_if_req = 0; u1_if_addr = 0; u1_ls_req = 0; u1_ls_we = 0; u1_ls_be = 0;
        u1_ls_addr = 0; u1_ls_wdata = 0; u1_mem_rdata = 0;

        // Reset: requests present but every output must stay 0.
        #2;
        if_req = 1'b1;
        ls_req = 1'b1;
        #1;
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_ls_gnt", 64'(ls_gnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fetch read
        mem_rdata = 32'h0000_0013;
        do_txn(1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 32'h0000_0013, w);
        chk("fetch_gnt_first_cycle", 64'(w), 64'd0);

        // Both requesting continuously
        mem_rdata = 32'h0BAD_F00D;
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h300; ls_wdata = 32'h0;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_ls = (k % 2 == 0);
`else
                exp_ls = 1'b1;
`endif
                chk("contend_gnt_owner", 64'({if_gnt, ls_gnt}), exp_ls ? 64'd1 : 64'd2);
                sb.push_back('{ls: exp_ls, rdata: 32'h0BAD_F00D, due: cyc + 2});
                k++;
            end
        end
        chk("contend_gnt_count", 64'(k), 64'd4);
        @(posedge clk); #1;
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;

        // Store: rdata must read 0 even though memory returns data
        mem_rdata = 32'hDEAD_BEEF;
        do_txn(1'b1, 1'b1, 4'b0011, 32'h7000, 32'h0000_ABCD, 32'h0, w);
        chk("store_gnt_first_cycle", 64'(w), 64'd0);

        // Load
        mem_rdata = 32'h1234_5678;
        do_txn(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 32'h1234_5678, w);

        // ls request raised during a fetch's BUSY window
        mem_rdata = 32'h55AA_55AA;
        if_req = 1'b1; if_addr = 32'h44;
        wait_gnt(1'b0, gc, ok);
        if (ok) sb.push_back('{ls: 1'b0, rdata: 32'h55AA_55AA, due: gc + 2});
        @(posedge clk); #1;
        if_req = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h88;
        wait_gnt(1'b1, gc2, ok2);
        chk("ls_gnt_after_busy", 64'(gc2 - gc), 64'd3);
        if (ok2) sb.push_back('{ls: 1'b1, rdata: 32'h55AA_55AA, due: gc2 + 2});
        @(posedge clk); #1;
        ls_req = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;

        // Reset in the first BUSY cycle of a fetch: abandoned, no rvalid afterwards
        mem_rdata = 32'h0000_0013;
        if_req = 1'b1; if_addr = 32'h40;
        wait_gnt(1'b0, gc, ok);
        @(posedge clk); #1;
        if_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst_mem_be", 64'(mem_be), 64'd0);
        chk("midrst_if_rvalid", 64'(if_rvalid), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        do_txn(1'b0, 1'b0, 4'hF, 32'h80, 32'h0, 32'h0000_0013, w);
        chk("postrst_gnt_first_cycle", 64'(w), 64'd0);

        // MEM_LAT=1 back-to-back fetches: grant, rvalid, grant, rvalid ...
        u1_mem_rdata = 32'h0000_0077;
        u1_if_req = 1'b1; u1_if_addr = 32'h10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("lat1_gnt", 64'(u1_if_gnt), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("lat1_rvalid", 64'(u1_if_rvalid), (i % 2 == 1) ? 64'd1 : 64'd0);
            chk("lat1_rdata", 64'(u1_if_rdata), (i % 2 == 1) ? 64'h77 : 64'd0);
            chk("lat1_mem_req", 64'(u1_mem_req), (i % 2 == 1) ? 64'd1 : 64'd0);
            chk("lat1_busy", 64'(u1_busy), (i % 2 == 1) ? 64'd1 : 64'd0);
            chk("lat1_mem_addr", 64'(u1_mem_addr), (i % 2 == 1) ? 64'h10 : 64'd0);
            chk("lat1_mem_be", 64'(u1_mem_be), (i % 2 == 1) ? 64'hF : 64'd0);
            chk("lat1_mem_we_wdata", 64'({u1_mem_we, u1_mem_wdata}), 64'd0);
            chk("lat1_ls_idle", 64'({u1_ls_gnt, u1_ls_rvalid, u1_ls_rdata}), 64'd0);
        end
        @(posedge clk); #1;
        u1_if_req = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: memory read/write latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk_i  in  1  clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port if_req_i  in  1  fetch request, held until granted.
REQ-007 SHALL have port if_addr_i  in  AW  fetch address.
REQ-008 SHALL have ports if_gnt_o, if_rvalid_o  out  1 each  fetch grant; fetch data valid.
REQ-009 SHALL have port if_rdata_o  out  32  fetch data.
REQ-010 SHALL have ports ls_req_i, ls_we_i  in  1 each  load/store request; write enable.
REQ-011 SHALL have ports ls_be_i (in 4, byte enables), ls_addr_i (in AW), ls_wdata_i (in 32).
REQ-012 SHALL have ports ls_gnt_o, ls_rvalid_o  out  1 each, and ls_rdata_o  out  32.
REQ-013 SHALL have ports mem_req_o, mem_we_o (out 1), mem_be_o (out 4), mem_addr_o (out AW), mem_wdata_o (out 32), mem_rdata_i (in 32).
REQ-014 SHALL have port busy_o  out  1  transaction in flight.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY; at most one transaction in flight.
REQ-016 In IDLE with at least one request, SHALL assert exactly one gnt_o combinationally in that cycle, latch the winner's command, load cnt = MEM_LAT-1 and enter BUSY.
REQ-017 In BUSY, SHALL drive mem_req_o=1 and mem_we/be/addr/wdata from the latched command, held stable through every BUSY cycle.
REQ-018 In BUSY, SHALL decrement cnt each cycle.
REQ-019 In BUSY with cnt==0, SHALL pulse the owner's rvalid_o for exactly one cycle and enter IDLE.
REQ-020 Latency: grant in cycle t -> mem_req_o high in cycles t+1..t+MEM_LAT -> rvalid in cycle t+MEM_LAT; next grant no earlier than t+MEM_LAT+1.
REQ-021 Read rdata_o SHALL pass mem_rdata_i to the owner in its rvalid cycle; write completion SHALL pulse ls_rvalid_o with ls_rdata_o=0.
REQ-022 Outside an owner's rvalid cycle, that owner's rdata_o SHALL be 0.
REQ-023 Fetch requests SHALL be reads only (mem_we_o=0, mem_be_o=4'hF).
REQ-024 SHALL assert no gnt_o while BUSY; requests arriving in BUSY wait for IDLE.
REQ-025 A request withdrawn before grant SHALL be dropped with no side effect.
REQ-026 busy_o SHALL equal (state==BUSY).

Reset
REQ-027 On rst_ni low, SHALL enter IDLE asynchronously and clear cnt and the latched command.
REQ-028 On rst_ni low, SHALL drive all outputs to 0 and set the round-robin last-owner register to IF.
REQ-029 A transaction in flight at reset SHALL be abandoned: no rvalid after release, and the first post-reset grant follows REQ-016.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the requester not granted last, and update the last-owner register on every grant.
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: SHALL apply fixed priority, ls over if, with no last-owner register.

Structure
REQ-032 Package arb_pkg SHALL hold the FSM state enum (IDLE, BUSY), the owner enum (OWN_IF, OWN_LS) and the latched-command struct (we, be, addr, wdata, owner).
REQ-033 Winner selection SHALL live in sub-module mem_arb_sel (inputs: two requests, last owner; output: owner and valid), combinational only.

Verification
REQ-034 MEM_LAT=2, if_req_i only, addr 0x40, mem_rdata_i=0x00000013 -> if_gnt_o at t, mem_req_o at t+1..t+2, if_rvalid_o with 0x00000013 at t+2.
REQ-035 ls store to 0x7000, be=4'b0011, wdata 0xABCD -> mem_we_o=1, mem_be_o=0011 held both BUSY cycles; ls_rvalid_o at t+2 with ls_rdata_o=0.
REQ-036 Both requesters high continuously, fixed priority -> ls granted on every grant and if never granted; with ARB_ROUND_ROBIN_EN -> grants alternate LS, IF, LS, IF.
REQ-037 ls_req_i raised during BUSY -> no gnt until the cycle after rvalid; gnt in the first IDLE cycle.
REQ-038 rst_ni pulsed low at t+1 of a fetch -> outputs 0 immediately, no if_rvalid_o; after release, a new request is granted in its first cycle.
REQ-039 MEM_LAT=1 back-to-back fetches -> grant every 2 cycles, rvalid 1 cycle after each grant.
